// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - parametrised tick strobe, blink wave and tick counter
//
// Purpose: divides clk by the active divisor D to give a one-cycle Hz1_enable
// strobe, a blink square wave (half-period BLINK_DIV ticks) and a wrapping
// tick counter. Supports pause (enable) and synchronous restart (sync_clear).
// Optional feature macro: DIVIDER_RUNTIME_LOAD_EN adds div_load/div_value for
// changing the divisor at run time.
//
// Ports:
//   clk            in   1      system clock, rising edge
//   divider_reset  in   1      asynchronous active-low reset
//   enable         in   1      1 = count, 0 = freeze all state
//   sync_clear     in   1      synchronous restart of all counters
//   div_load       in   1      load div_value (DIVIDER_RUNTIME_LOAD_EN only)
//   div_value      in   CNT_W  new divisor, 0 ignored (DIVIDER_RUNTIME_LOAD_EN only)
//   Hz1_enable     out  1      one-cycle tick strobe
//   blink          out  1      square wave toggling every BLINK_DIV ticks
//   tick_count     out  SEC_W  ticks since reset/clear, wraps

module tick_generator #(
  parameter int DIV       = 1000,
  parameter int CNT_W     = 16,
  parameter int BLINK_DIV = 1,
  parameter int SEC_W     = 8
) (
  input  logic             clk,
  input  logic             divider_reset,
  input  logic             enable,
  input  logic             sync_clear,
`ifdef DIVIDER_RUNTIME_LOAD_EN
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
`endif
  output logic             Hz1_enable,
  output logic             blink,
  output logic [SEC_W-1:0] tick_count
);

  if (DIV < 1) begin : g_bad_div
    $error("tick_generator: DIV must be >= 1");
  end
  if (CNT_W < 31 && (2 ** CNT_W) < DIV) begin : g_bad_cnt_w
    $error("tick_generator: CNT_W too narrow for DIV");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("tick_generator: BLINK_DIV must be >= 1");
  end

  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

  logic [CNT_W-1:0] prescaler;
  logic [BCW-1:0]   blink_cnt;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] div_last;
  logic             load_ok;

`ifdef DIVIDER_RUNTIME_LOAD_EN
  // A zero divisor would never tick, so such a load is dropped entirely.
  assign load_ok = div_load && (div_value != '0);

  always_ff @(posedge clk or negedge divider_reset) begin
    if (!divider_reset) begin
      div_active <= CNT_W'(DIV);
    end else if (!sync_clear && load_ok) begin
      div_active <= div_value;
    end
  end
`else
  assign load_ok    = 1'b0;
  assign div_active = CNT_W'(DIV);
`endif

  // When DIV == 2**CNT_W the truncated divisor is 0 and this wraps to all
  // ones, which is still the correct terminal count.
  assign div_last = div_active - CNT_W'(1);

  always_ff @(posedge clk or negedge divider_reset) begin
    if (!divider_reset) begin
      prescaler  <= '0;
      blink_cnt  <= '0;
      Hz1_enable <= 1'b0;
      blink      <= 1'b0;
      tick_count <= '0;
    end else if (sync_clear) begin
      prescaler  <= '0;
      blink_cnt  <= '0;
      Hz1_enable <= 1'b0;
      blink      <= 1'b0;
      tick_count <= '0;
    end else if (load_ok) begin
      // New divisor restarts the period; blink state and count carry on.
      prescaler  <= '0;
      Hz1_enable <= 1'b0;
    end else if (enable) begin
      if (prescaler == div_last) begin
        prescaler  <= '0;
        Hz1_enable <= 1'b1;
        tick_count <= tick_count + SEC_W'(1);
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + BCW'(1);
        end
      end else begin
        prescaler  <= prescaler + CNT_W'(1);
        Hz1_enable <= 1'b0;
      end
    end else begin
      Hz1_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - randomized bench for tick_generator against a tick-count model
`timescale 1ns/100ps

module tb_tick_generator;

  localparam int DIV       = 4;
  localparam int CNT_W     = 4;
  localparam int BLINK_DIV = 2;
  localparam int SEC_W     = 3;
`ifdef DIVIDER_RUNTIME_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic divider_reset = 1'b0;
  logic enable = 1'b0;
  logic sync_clear = 1'b0;
`ifdef DIVIDER_RUNTIME_LOAD_EN
  logic             div_load = 1'b0;
  logic [CNT_W-1:0] div_value = '0;
`endif

  logic             hz_a, blink_a, hz_b, blink_b;
  logic [SEC_W-1:0] tc_a, tc_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #1 clk = ~clk;

  tick_generator #(.DIV(DIV), .CNT_W(CNT_W), .BLINK_DIV(BLINK_DIV), .SEC_W(SEC_W)) u_dut_a (
    .clk(clk), .divider_reset(divider_reset), .enable(enable), .sync_clear(sync_clear),
`ifdef DIVIDER_RUNTIME_LOAD_EN
    .div_load(div_load), .div_value(div_value),
`endif
    .Hz1_enable(hz_a), .blink(blink_a), .tick_count(tc_a)
  );

  tick_generator #(.DIV(1), .CNT_W(CNT_W), .BLINK_DIV(BLINK_DIV), .SEC_W(SEC_W)) u_dut_b (
    .clk(clk), .divider_reset(divider_reset), .enable(enable), .sync_clear(sync_clear),
`ifdef DIVIDER_RUNTIME_LOAD_EN
    .div_load(div_load), .div_value(div_value),
`endif
    .Hz1_enable(hz_b), .blink(blink_b), .tick_count(tc_b)
  );

  // Reference: per instance, enabled edges since the last period start, the
  // current divisor and the total number of ticks since reset/clear. blink and
  // tick_count are derived arithmetically from the total tick count.
  int phase [2];
  int d     [2];
  int ticks [2];
  bit hz    [2];

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0;
      ticks[i] = 0;
      hz[i]    = 1'b0;
    end
    d[0] = DIV;
    d[1] = 1;
  endtask

  task automatic model_step(input bit clr, input bit ld, input int val, input bit en);
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        phase[i] = 0;
        ticks[i] = 0;
        hz[i]    = 1'b0;
      end else if (ld && val != 0) begin
        d[i]     = val;
        phase[i] = 0;
        hz[i]    = 1'b0;
      end else if (en) begin
        phase[i]++;
        hz[i] = (phase[i] == d[i]);
        if (hz[i]) begin
          phase[i] = 0;
          ticks[i]++;
        end
      end else begin
        hz[i] = 1'b0;
      end
    end
  endtask

  task automatic compare();
    check("a_hz",    int'(hz_a),    int'(hz[0]));
    check("a_blink", int'(blink_a), (ticks[0] / BLINK_DIV) % 2);
    check("a_count", int'(tc_a),    ticks[0] % (1 << SEC_W));
    check("b_hz",    int'(hz_b),    int'(hz[1]));
    check("b_blink", int'(blink_b), (ticks[1] / BLINK_DIV) % 2);
    check("b_count", int'(tc_b),    ticks[1] % (1 << SEC_W));
  endtask

  // Called just after a falling edge: drive inputs, predict the next rising
  // edge, then compare at the following falling edge.
  task automatic cycle(input bit en, input bit clr, input bit ld, input int val);
    enable     = en;
    sync_clear = clr;
`ifdef DIVIDER_RUNTIME_LOAD_EN
    div_load  = ld;
    div_value = CNT_W'(val);
`endif
    if (divider_reset) model_step(clr, ld && LOAD_EN, val, en);
    @(negedge clk);
    compare();
  endtask

  task automatic async_reset_check();
    divider_reset = 1'b0;
    #0.2;
    model_reset();
    check("rst_a_hz",    int'(hz_a),    0);
    check("rst_a_blink", int'(blink_a), 0);
    check("rst_a_count", int'(tc_a),    0);
    check("rst_b_hz",    int'(hz_b),    0);
    check("rst_b_count", int'(tc_b),    0);
  endtask

  initial begin
    model_reset();
    // Held in reset for 10 ns.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compare();
    end
    divider_reset = 1'b1;

    // Free running: first tick on the 4th edge, tick_count wraps past 7.
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 0);

    // Pause with a partly advanced prescaler, then resume.
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 0);

    // Mid-count asynchronous reset, seen before the next edge.
    async_reset_check();
    @(negedge clk);
    compare();
    divider_reset = 1'b1;

    // Randomized traffic: pauses, clears, loads (including zero) and
    // occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      bit en, clr, ld;
      int val;
      if ($urandom_range(0, 199) == 0) begin
        async_reset_check();
        @(negedge clk);
        compare();
        divider_reset = 1'b1;
      end
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 24) == 0);
      val = $urandom_range(0, 5);
      cycle(en, clr, ld, val);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
